// File: rtl/local_injection_scheduler.sv
// local_injection_scheduler: shares the router's local injection port among
// N_REQ on-tile requesters. Round-robin grant per cycle, wormhole packet
// atomicity per VC via a per-VC lock table, per-VC on/off backpressure, and a
// registered output stage driving wr_en_out/flit_out.
//
// Flit layout: [1:0] flit type (0=HEADER, 1=BODY, 2=TAIL, 3=HT),
// [VCW+1:2] vc field (overwritten with req_vc on the way out), payload above.
//
// Optional feature: define LOCAL_INJECTION_SCHEDULER_AGE_PRIORITY_EN to add
// per-requester age counters; requesters aged >= AGE_LIMIT pre-empt the
// round-robin choice, lowest index first. The AGE_LIMIT parameter only exists
// in that build.
`ifndef VC_PER_PORT
`define VC_PER_PORT 4
`endif

// Per-requester eligibility against the VC lock table and backpressure.
module lis_req_elig #(
  parameter int VCN = 4,
  parameter int VCW = 2,
  parameter int RW  = 2,
  parameter int IDX = 0
)(
  input  logic                   valid,
  input  logic [1:0]             ftype,
  input  logic [VCW-1:0]         vc,
  input  logic [VCN-1:0]         on_off,
  input  logic [VCN-1:0]         locked,
  input  logic [VCN-1:0][RW-1:0] owner,
  output logic                   elig
);
  localparam logic [1:0] T_HEAD = 2'd0, T_BODY = 2'd1, T_TAIL = 2'd2, T_HT = 2'd3;
  logic opener, follower, mine;
  assign opener   = (ftype == T_HEAD) || (ftype == T_HT);
  assign follower = (ftype == T_BODY) || (ftype == T_TAIL);
  assign mine     = locked[vc] && (owner[vc] == RW'(IDX));
  assign elig     = valid && !on_off[vc] && ((mine && follower) || (!locked[vc] && opener));
endmodule

module local_injection_scheduler #(
  parameter int N_REQ     = 4,
`ifdef LOCAL_INJECTION_SCHEDULER_AGE_PRIORITY_EN
  parameter int AGE_LIMIT = 16,
`endif
  parameter int FLIT_W    = 32,
  localparam int VCN = `VC_PER_PORT,
  localparam int VCW = (VCN > 1) ? $clog2(VCN) : 1,
  localparam int RW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][FLIT_W-1:0] req_flit,
  input  logic [N_REQ-1:0][VCW-1:0]    req_vc,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [VCN-1:0]               on_off_in,
  output logic                         wr_en_out,
  output logic [FLIT_W-1:0]            flit_out,
  output logic [VCN-1:0]               vc_locked,
  output logic [VCN-1:0][RW-1:0]       vc_owner
);
  localparam logic [1:0] T_HEAD = 2'd0, T_TAIL = 2'd2;

  logic [N_REQ-1:0]        elig, elig_q;
  logic [RW-1:0]           rr_ptr, ptr_nxt, gnt_idx, idx;
  logic [RW:0]             sum;
  logic                    found;
  logic [VCW-1:0]          gvc;
  logic [1:0]              gtype;
  logic [FLIT_W-1:0]       out_nxt;
  logic [VCN-1:0]          lock_nxt;
  logic [VCN-1:0][RW-1:0]  own_nxt;

  for (genvar r = 0; r < N_REQ; r++) begin : g_req
    lis_req_elig #(.VCN(VCN), .VCW(VCW), .RW(RW), .IDX(r)) u_elig (
      .valid(req_valid[r]), .ftype(req_flit[r][1:0]), .vc(req_vc[r]),
      .on_off(on_off_in), .locked(vc_locked), .owner(vc_owner), .elig(elig[r])
    );
  end

  // Nothing is granted while reset is asserted.
  assign elig_q = elig & {N_REQ{reset}};

`ifdef LOCAL_INJECTION_SCHEDULER_AGE_PRIORITY_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [N_REQ-1:0][AW-1:0] age;

  // Age counts waiting-while-eligible cycles; cleared on grant or when idle.
  always_ff @(posedge clk) begin
    for (int r = 0; r < N_REQ; r++) begin
      if (!reset || !req_valid[r] || req_ready[r]) age[r] <= '0;
      else if (elig_q[r] && age[r] != AW'(AGE_LIMIT)) age[r] <= age[r] + 1'b1;
    end
  end
`endif

  // Pick the first eligible requester at or after the RR pointer; aged
  // requesters (when enabled) override, lowest index winning.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (RW+1)'(k);
      if (sum >= (RW+1)'(N_REQ)) sum = sum - (RW+1)'(N_REQ);
      idx = sum[RW-1:0];
      if (!found && elig_q[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
`ifdef LOCAL_INJECTION_SCHEDULER_AGE_PRIORITY_EN
    for (int r = N_REQ-1; r >= 0; r--) begin
      if (elig_q[r] && age[r] >= AW'(AGE_LIMIT)) begin
        found   = 1'b1;
        gnt_idx = RW'(r);
      end
    end
`endif
  end

  assign req_ready = found ? (N_REQ'(1) << gnt_idx) : '0;
  assign ptr_nxt   = (gnt_idx == RW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  assign gvc       = req_vc[gnt_idx];
  assign gtype     = req_flit[gnt_idx][1:0];

  // Outgoing flit carries the requester's VC in its vc field.
  always_comb begin
    out_nxt = req_flit[gnt_idx];
    out_nxt[2 +: VCW] = gvc;
  end

  // Lock table next state: HEADER acquires, TAIL releases, BODY/HT leave it.
  always_comb begin
    lock_nxt = vc_locked;
    own_nxt  = vc_owner;
    if (found && gtype == T_HEAD) begin
      lock_nxt[gvc] = 1'b1;
      own_nxt[gvc]  = gnt_idx;
    end else if (found && gtype == T_TAIL) begin
      lock_nxt[gvc] = 1'b0;
    end
  end

  // Lock table and RR pointer state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vc_locked <= '0;
      vc_owner  <= '0;
      rr_ptr    <= '0;
    end else begin
      vc_locked <= lock_nxt;
      vc_owner  <= own_nxt;
      if (found) rr_ptr <= ptr_nxt;
    end
  end

  // Registered output stage; flit_out holds its last value when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_out <= 1'b0;
      flit_out  <= '0;
    end else begin
      wr_en_out <= found;
      if (found) flit_out <= out_nxt;
    end
  end
endmodule
